// File: rtl/vi_pkg.sv
// Shared types and field layout for the vector issue controller.
// Holds the instruction field offsets, widths and FSM state type.
package vi_pkg;

    localparam int VI_W = 100;
    localparam int VL_W = 9;
    localparam int ID_W = 3;

    // Field widths, LSB-first packing order.
    localparam int W_VS1      = 5;
    localparam int W_VS2      = 5;
    localparam int W_VD       = 5;
    localparam int W_RS1      = 32;
    localparam int W_RS2      = 32;
    localparam int W_UIMM5    = 5;
    localparam int W_FUNCT    = 6;
    localparam int W_PERMUTE  = 1;
    localparam int W_MASK_EN  = 1;
    localparam int W_ALUSRC   = 1;
    localparam int W_DMR      = 1;
    localparam int W_DMW      = 1;
    localparam int W_REG_WE   = 1;
    localparam int W_MEM_REG  = 1;
    localparam int W_XOUT     = 1;
    localparam int W_MODE_LSU = 2;

    localparam int OFF_VS1      = 0;
    localparam int OFF_VS2      = OFF_VS1 + W_VS1;
    localparam int OFF_VD       = OFF_VS2 + W_VS2;
    localparam int OFF_RS1      = OFF_VD + W_VD;
    localparam int OFF_RS2      = OFF_RS1 + W_RS1;
    localparam int OFF_UIMM5    = OFF_RS2 + W_RS2;
    localparam int OFF_FUNCT    = OFF_UIMM5 + W_UIMM5;
    localparam int OFF_PERMUTE  = OFF_FUNCT + W_FUNCT;
    localparam int OFF_MASK_EN  = OFF_PERMUTE + W_PERMUTE;
    localparam int OFF_ALUSRC   = OFF_MASK_EN + W_MASK_EN;
    localparam int OFF_DMR      = OFF_ALUSRC + W_ALUSRC;
    localparam int OFF_DMW      = OFF_DMR + W_DMR;
    localparam int OFF_REG_WE   = OFF_DMW + W_DMW;
    localparam int OFF_MEM_REG  = OFF_REG_WE + W_REG_WE;
    localparam int OFF_XOUT     = OFF_MEM_REG + W_MEM_REG;
    localparam int OFF_MODE_LSU = OFF_XOUT + W_XOUT;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } vi_state_e;

    function automatic logic vi_is_mem(input logic [VI_W-1:0] ins);
        return ins[OFF_DMR] | ins[OFF_DMW];
    endfunction

    function automatic logic vi_is_xout(input logic [VI_W-1:0] ins);
        return ins[OFF_XOUT];
    endfunction

endpackage

// File: rtl/vi_fifo.sv
// Synchronous FIFO with flush and per-entry visibility.
// Ports: push/wdata in, pop/rdata out, full/empty, ent_valid/ent_data per slot.
module vi_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [W-1:0]              wdata,
    input  logic                      pop,
    input  logic                      flush,
    output logic [W-1:0]              rdata,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH-1:0][W-1:0]   ent_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]             wr_q, wr_d;
    logic [AW:0]             rd_q, rd_d;
    logic [AW:0]             cnt;
    logic [AW-1:0]           off;
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

    // Extra pointer MSB distinguishes full from empty.
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) &&
                      (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata    = mem_q[rd_q[AW-1:0]];
    assign ent_data = mem_q;
    assign cnt      = wr_q - rd_q;

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        off       = '0;
        ent_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = AW'(i) - rd_q[AW-1:0];
            ent_valid[i] = ({1'b0, off} < cnt);
        end
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (flush) begin
            rd_d = wr_q;
        end else begin
            if (push && !full) begin
                mem_d[wr_q[AW-1:0]] = wdata;
                wr_d = wr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_d = rd_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/v_issue_ctrl.sv
// In-order issue controller feeding the vector unit from a small queue.
// Ports: in_* decode side, v_* vector side, status and sticky watchdog error.
module v_issue_ctrl
    import vi_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [VI_W-1:0] in_instr,
    input  logic [VL_W-1:0] in_vl,
    input  logic            flush,
    output logic            v_start,
    output logic [ID_W-1:0] v_id,
    output logic [VI_W-1:0] v_instr,
    output logic [VL_W-1:0] v_vl,
    output logic            v_clear,
    input  logic            v_stall,
    input  logic            v_done,
    output logic            q_empty,
    output logic            vec_busy,
    output logic            mem_pending,
    output logic            xout_pending,
    output logic            err_timeout
);

    localparam int EW   = VI_W + VL_W;
    localparam int WD_W = $clog2(TIMEOUT);

    vi_state_e state_q, state_d;

    logic            v_start_q, v_start_d;
    logic            v_clear_q, v_clear_d;
    logic            err_q, err_d;
    logic [ID_W-1:0] id_cnt_q, id_cnt_d;
    logic [ID_W-1:0] v_id_q, v_id_d;
    logic [VI_W-1:0] v_instr_q, v_instr_d;
    logic [VL_W-1:0] v_vl_q, v_vl_d;
    logic [WD_W-1:0] wd_q, wd_d;

    logic                     q_full;
    logic                     q_empty_w;
    logic [EW-1:0]            head;
    logic [DEPTH-1:0]         ent_valid;
    logic [DEPTH-1:0][EW-1:0] ent_data;
    logic [DEPTH-1:0][EW-1:0] unused_ent;

    logic push;
    logic issue;
    logic abort;
    logic wd_hit;
    logic busy;

    assign busy     = (state_q == ST_BUSY);
    assign in_ready = !q_full && !flush;
    assign push     = in_valid && in_ready;
    assign wd_hit   = (wd_q == WD_W'(TIMEOUT - 1));
    assign issue    = !busy && !flush && !q_empty_w && !v_stall;
    // A done arriving on the last watchdog cycle still completes normally.
    assign abort    = busy && !flush && !v_done && wd_hit;

    vi_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .wdata     ({in_instr, in_vl}),
        .pop       (issue),
        .flush     (flush),
        .rdata     (head),
        .full      (q_full),
        .empty     (q_empty_w),
        .ent_valid (ent_valid),
        .ent_data  (ent_data)
    );

    assign unused_ent = ent_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (issue) state_d = ST_BUSY;
            ST_BUSY: if (flush || v_done || wd_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        v_start_d = issue;
        v_clear_d = (busy && flush) || abort;
        err_d     = err_q || abort;
        id_cnt_d  = id_cnt_q;
        v_id_d    = v_id_q;
        v_instr_d = v_instr_q;
        v_vl_d    = v_vl_q;
        // Counter idles at zero so it starts clean on each issue.
        wd_d      = busy ? wd_q + WD_W'(1) : '0;
        if (issue) begin
            id_cnt_d  = id_cnt_q + ID_W'(1);
            v_id_d    = id_cnt_q;
            v_instr_d = head[VL_W +: VI_W];
            v_vl_d    = head[VL_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_start_q <= 1'b0;
            v_clear_q <= 1'b0;
            err_q     <= 1'b0;
            id_cnt_q  <= '0;
            v_id_q    <= '0;
            v_instr_q <= '0;
            v_vl_q    <= '0;
            wd_q      <= '0;
        end else begin
            v_start_q <= v_start_d;
            v_clear_q <= v_clear_d;
            err_q     <= err_d;
            id_cnt_q  <= id_cnt_d;
            v_id_q    <= v_id_d;
            v_instr_q <= v_instr_d;
            v_vl_q    <= v_vl_d;
            wd_q      <= wd_d;
        end
    end

    // Queued entries plus the in-flight latch while busy.
    always_comb begin
        mem_pending  = busy && vi_is_mem(v_instr_q);
        xout_pending = busy && vi_is_xout(v_instr_q);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                mem_pending  = mem_pending |
                               vi_is_mem(ent_data[i][VL_W +: VI_W]);
                xout_pending = xout_pending |
                               vi_is_xout(ent_data[i][VL_W +: VI_W]);
            end
        end
    end

    assign v_start     = v_start_q;
    assign v_clear     = v_clear_q;
    assign v_id        = v_id_q;
    assign v_instr     = v_instr_q;
    assign v_vl        = v_vl_q;
    assign err_timeout = err_q;
    assign q_empty     = q_empty_w;
    assign vec_busy    = !q_empty_w || busy;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Scoreboard bench for v_issue_ctrl: queued pushes are compared
// against each v_start; flush, timeout and pending flags checked directly.
module tb_v_issue_ctrl;
    import vi_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [VI_W-1:0] in_instr;
    logic [VL_W-1:0] in_vl;
    logic            flush;
    logic            v_start;
    logic [ID_W-1:0] v_id;
    logic [VI_W-1:0] v_instr;
    logic [VL_W-1:0] v_vl;
    logic            v_clear;
    logic            v_stall;
    logic            v_done;
    logic            q_empty;
    logic            vec_busy;
    logic            mem_pending;
    logic            xout_pending;
    logic            err_timeout;

    v_issue_ctrl #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_vl        (in_vl),
        .flush        (flush),
        .v_start      (v_start),
        .v_id         (v_id),
        .v_instr      (v_instr),
        .v_vl         (v_vl),
        .v_clear      (v_clear),
        .v_stall      (v_stall),
        .v_done       (v_done),
        .q_empty      (q_empty),
        .vec_busy     (vec_busy),
        .mem_pending  (mem_pending),
        .xout_pending (xout_pending),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VI_W-1:0] instr;
        logic [VL_W-1:0] vl;
    } exp_t;

    exp_t            sb[$];
    int              st_log[$];
    logic [ID_W-1:0] id_log[$];
    logic [ID_W-1:0] exp_id;
    int              n_tot = 0;
    int              n_bad = 0;
    int              cyc = 0;
    int              ctr = -1;
    int              pv = 0;
    int              pv0;
    int              s0;
    bit              acc;
    bit              saw_start;
    bit              prev_start;
    bit              auto_done;
    bit              wrap_seen;
    logic [ID_W-1:0] nxt;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [VI_W-1:0] mk(input int vd, input bit dmr,
                                           input bit xo);
        logic [VI_W-1:0] r;
        r = '0;
        r[OFF_RS1 +: W_RS1] = $urandom;
        r[OFF_VD +: W_VD]   = vd[4:0];
        r[OFF_DMR]          = dmr;
        r[OFF_XOUT]         = xo;
        return r;
    endfunction

    // One clock: log push/flush into the scoreboard, then sample and
    // act as the vector unit (v_done in the 5th cycle of each instr,
    // counting the start cycle).
    task automatic tick();
        exp_t e;
        acc = in_valid && in_ready && !reset;
        if (flush) sb.delete();
        if (acc) begin
            e.instr = in_instr;
            e.vl    = in_vl;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        saw_start = v_start;
        if (v_start) begin
            if (sb.size() == 0) begin
                check("spurious_start", v_start, 1'b0);
            end else begin
                e = sb.pop_front();
                check("instr", v_instr, e.instr);
                check("vl", v_vl, e.vl);
                check("id", v_id, exp_id);
            end
            check("start_width", prev_start, 1'b0);
            if (id_log.size() > 0 && id_log[$] == 3'd7 && v_id == 3'd0)
                wrap_seen = 1'b1;
            id_log.push_back(v_id);
            exp_id = exp_id + 3'd1;
            st_log.push_back(cyc);
            ctr = 4;
        end else if (ctr >= 0) begin
            ctr--;
        end
        prev_start = v_start;
        v_done = auto_done && (ctr == 0);
    endtask

    task automatic push(input logic [VI_W-1:0] ins, input logic [8:0] vl);
        in_valid = 1'b1;
        in_instr = ins;
        in_vl    = vl;
        for (int i = 0; i < 40; i++) begin
            pv = cyc;
            tick();
            if (acc) break;
        end
        check("push_accept", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (saw_start) break;
        end
        check("start_seen", saw_start, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (!vec_busy) break;
            tick();
        end
        check("drain", vec_busy, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        in_vl = '0;
        flush = 1'b0;
        v_stall = 1'b0;
        v_done = 1'b0;
        auto_done = 1'b0;
        wrap_seen = 1'b0;
        exp_id = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_q_empty", q_empty, 1'b1);
        check("rst_busy", vec_busy, 1'b0);
        check("rst_start", v_start, 1'b0);
        check("rst_clear", v_clear, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_mem", mem_pending, 1'b0);
        check("rst_xout", xout_pending, 1'b0);
        check("rst_id", v_id, 3'd0);
        reset = 1'b0;
        tick();

        // Reset while an instruction is in flight.
        push(mk(9, 1, 1), 9'd20);
        wait_start();
        tick();
        check("t1_busy", vec_busy, 1'b1);
        check("t1_mem", mem_pending, 1'b1);
        reset = 1'b1;
        tick();
        check("t1_start", v_start, 1'b0);
        check("t1_busy_rst", vec_busy, 1'b0);
        check("t1_rdy", in_ready, 1'b1);
        check("t1_qe", q_empty, 1'b1);
        check("t1_instr", v_instr, '0);
        check("t1_vl", v_vl, 9'd0);
        check("t1_mem_rst", mem_pending, 1'b0);
        check("t1_xout_rst", xout_pending, 1'b0);
        reset = 1'b0;
        sb.delete();
        exp_id = '0;
        ctr = -1;
        tick();

        // Three back-to-back instructions, ordered, spaced by 6.
        auto_done = 1'b1;
        st_log.delete();
        push(mk(1, 0, 0), 9'd16);
        pv0 = pv;
        push(mk(2, 0, 0), 9'd32);
        push(mk(3, 0, 0), 9'd256);
        drain();
        check("t2_starts", st_log.size(), 3);
        if (st_log.size() == 3) begin
            check("t2_lat", st_log[0] - pv0, 2);
            check("t2_sp01", st_log[1] - st_log[0], 6);
            check("t2_sp12", st_log[2] - st_log[1], 6);
        end

        // v_done while idle does nothing.
        v_done = 1'b1;
        tick();
        check("idle_done_busy", vec_busy, 1'b0);
        check("idle_done_clr", v_clear, 1'b0);

        // Stall fills the queue; held 5th enters on the first pop.
        st_log.delete();
        v_stall = 1'b1;
        for (int k = 0; k < 4; k++) push(mk(10 + k, 0, 0), 9'(k + 1));
        check("t3_full_rdy", in_ready, 1'b0);
        check("t3_qe", q_empty, 1'b0);
        in_valid = 1'b1;
        in_instr = mk(14, 0, 0);
        in_vl    = 9'd5;
        tick();
        tick();
        check("t3_held", sb.size(), 4);
        v_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (acc) break;
        end
        check("t3_5th_acc", acc, 1'b1);
        in_valid = 1'b0;
        drain();
        check("t3_starts", st_log.size(), 5);

        // Flush while busy with two queued.
        auto_done = 1'b0;
        st_log.delete();
        id_log.delete();
        push(mk(20, 0, 0), 9'd7);
        push(mk(21, 0, 0), 9'd8);
        push(mk(22, 0, 0), 9'd9);
        check("t4_one_start", st_log.size(), 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(23, 0, 0);
        #1;
        check("t4_flush_rdy", in_ready, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_clear", v_clear, 1'b1);
        check("t4_qe", q_empty, 1'b1);
        check("t4_busy", vec_busy, 1'b0);
        tick();
        check("t4_clear_w", v_clear, 1'b0);
        repeat (6) tick();
        check("t4_no_start", st_log.size(), 1);
        auto_done = 1'b1;
        push(mk(24, 0, 0), 9'd10);
        drain();
        check("t4_starts", st_log.size(), 2);
        if (id_log.size() == 2) begin
            nxt = id_log[0] + 3'd1;
            check("t4_id_next", id_log[1], nxt);
        end

        // Watchdog abort after 16 busy cycles; queue kept, error sticky.
        auto_done = 1'b0;
        v_stall = 1'b1;
        push(mk(5, 0, 0), 9'd1);
        push(mk(6, 0, 0), 9'd2);
        v_stall = 1'b0;
        wait_start();
        s0 = cyc;
        for (int i = 0; i < 40; i++) begin
            if (v_clear) break;
            tick();
        end
        check("t5_wd_cycle", cyc - s0, 16);
        check("t5_clear", v_clear, 1'b1);
        check("t5_err", err_timeout, 1'b1);
        auto_done = 1'b1;
        wait_start();
        check("t5_err_hold", err_timeout, 1'b1);
        drain();
        check("t5_err_end", err_timeout, 1'b1);
        check("t5_mem_idle", mem_pending, 1'b0);
        check("t5_xout_idle", xout_pending, 1'b0);

        // Pending flags follow queued and in-flight instructions.
        v_stall = 1'b1;
        push(mk(7, 1, 0), 9'd3);
        push(mk(8, 0, 1), 9'd4);
        check("t6_mem_q", mem_pending, 1'b1);
        check("t6_xout_q", xout_pending, 1'b1);
        v_stall = 1'b0;
        wait_start();
        check("t6_mem_fly", mem_pending, 1'b1);
        repeat (4) tick();
        check("t6_mem_done", mem_pending, 1'b1);
        tick();
        check("t6_mem_drop", mem_pending, 1'b0);
        check("t6_xout_q2", xout_pending, 1'b1);
        wait_start();
        check("t6_xout_fly", xout_pending, 1'b1);
        repeat (4) tick();
        check("t6_xout_done", xout_pending, 1'b1);
        tick();
        check("t6_xout_drop", xout_pending, 1'b0);
        drain();

        // Nine more issues wrap the id counter through 7 -> 0.
        st_log.delete();
        id_log.delete();
        wrap_seen = 1'b0;
        for (int k = 0; k < 9; k++) push(mk(k, 0, 0), 9'(k * 3));
        drain();
        check("t6_nine", st_log.size(), 9);
        check("t6_wrap", wrap_seen, 1'b1);
        check("sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
